// File: rtl/sfft_sequencer_if.sv
// Host/config and SFFT-control signal bundle for the SFFT sequencer.
// The sequencer takes the slave side; a host or bench drives the master side.
interface sfft_sequencer_if #(
  parameter int BITWIDTH = 8,
  parameter int NUMTW    = 4,
  parameter int TWAW     = $clog2(NUMTW)
);
  logic                iStart;
  logic                iAbort;
  logic                iCfgWe;
  logic [TWAW-1:0]     iCfgAddr;
  logic [BITWIDTH-1:0] iCfgReal;
  logic [BITWIDTH-1:0] iCfgImg;
  logic                oBusy;
  logic                oDone;
  logic                oLoadW;
  logic [BITWIDTH-1:0] oWReal;
  logic [BITWIDTH-1:0] oWImg;
  logic                oClr;
  logic                oEn;
  logic [BITWIDTH-1:0] oCycle;
  logic                oLast;

  modport master (
    output iStart, iAbort, iCfgWe, iCfgAddr, iCfgReal, iCfgImg,
    input  oBusy, oDone, oLoadW, oWReal, oWImg, oClr, oEn, oCycle, oLast
  );

  modport slave (
    input  iStart, iAbort, iCfgWe, iCfgAddr, iCfgReal, iCfgImg,
    output oBusy, oDone, oLoadW, oWReal, oWImg, oClr, oEn, oCycle, oLast
  );
endinterface

// File: rtl/sfft_sequencer.sv
// SFFT control sequencer: twiddle load, one-cycle clear, a 2^BITWIDTH-cycle
// enable window, then a done pulse. All outputs come straight from flops.
module sfft_sequencer #(
  parameter int BITWIDTH = 8,
  parameter int NUMTW    = 4,
  parameter int TWAW     = $clog2(NUMTW)
) (
  input  logic           iClk,
  input  logic           iRst,
  sfft_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, CLEAR, RUN, DONE} state_t;

  localparam logic [TWAW:0]   NUMTW_W  = (TWAW+1)'(NUMTW);
  localparam logic [TWAW-1:0] LAST_IDX = TWAW'(NUMTW - 1);

  state_t              state_reg;
  logic [TWAW-1:0]     ld_idx_reg;
  logic                busy_reg;
  logic                done_reg;
  logic                loadw_reg;
  logic                clr_reg;
  logic                en_reg;
  logic                last_reg;
  logic [BITWIDTH-1:0] wreal_reg;
  logic [BITWIDTH-1:0] wimg_reg;
  logic [BITWIDTH-1:0] cycle_reg;

  logic [BITWIDTH-1:0] tw_real_reg [NUMTW];
  logic [BITWIDTH-1:0] tw_img_reg  [NUMTW];

  logic                cfg_wr;
  logic                cfg_hit0;
  logic [BITWIDTH-1:0] first_real;
  logic [BITWIDTH-1:0] first_img;
  logic [TWAW-1:0]     ld_idx_next;
  logic [BITWIDTH-1:0] cycle_next;

  assign cfg_wr   = (state_reg == IDLE) && bus.iCfgWe && ({1'b0, bus.iCfgAddr} < NUMTW_W);
  assign cfg_hit0 = cfg_wr && (bus.iCfgAddr == '0);

  // Entry 0 is presented on the same edge a start is taken, so a write to
  // entry 0 in that cycle must be forwarded rather than read from the table.
  assign first_real  = cfg_hit0 ? bus.iCfgReal : tw_real_reg[0];
  assign first_img   = cfg_hit0 ? bus.iCfgImg  : tw_img_reg[0];
  assign ld_idx_next = ld_idx_reg + 1'b1;
  assign cycle_next  = cycle_reg + 1'b1;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      for (int i = 0; i < NUMTW; i++) begin
        tw_real_reg[i] <= '0;
        tw_img_reg[i]  <= '0;
      end
    end else if (cfg_wr) begin
      tw_real_reg[bus.iCfgAddr] <= bus.iCfgReal;
      tw_img_reg[bus.iCfgAddr]  <= bus.iCfgImg;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_reg  <= IDLE;
      ld_idx_reg <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      loadw_reg  <= 1'b0;
      clr_reg    <= 1'b0;
      en_reg     <= 1'b0;
      last_reg   <= 1'b0;
      wreal_reg  <= '0;
      wimg_reg   <= '0;
      cycle_reg  <= '0;
    end else begin
      // Every output idles at zero; each state re-asserts what it drives.
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      loadw_reg <= 1'b0;
      clr_reg   <= 1'b0;
      en_reg    <= 1'b0;
      last_reg  <= 1'b0;
      wreal_reg <= '0;
      wimg_reg  <= '0;
      cycle_reg <= '0;

      case (state_reg)
        IDLE: begin
          if (bus.iStart) begin
            state_reg  <= LOAD;
            ld_idx_reg <= '0;
            busy_reg   <= 1'b1;
            loadw_reg  <= 1'b1;
            wreal_reg  <= first_real;
            wimg_reg   <= first_img;
          end
        end

        LOAD: begin
          if (bus.iAbort) begin
            state_reg <= IDLE;
          end else if (ld_idx_reg == LAST_IDX) begin
            state_reg <= CLEAR;
            busy_reg  <= 1'b1;
            clr_reg   <= 1'b1;
          end else begin
            ld_idx_reg <= ld_idx_next;
            busy_reg   <= 1'b1;
            loadw_reg  <= 1'b1;
            wreal_reg  <= tw_real_reg[ld_idx_next];
            wimg_reg   <= tw_img_reg[ld_idx_next];
          end
        end

        CLEAR: begin
          if (bus.iAbort) begin
            state_reg <= IDLE;
          end else begin
            state_reg <= RUN;
            busy_reg  <= 1'b1;
            en_reg    <= 1'b1;
          end
        end

        RUN: begin
          // Abort wins even on the final window cycle.
          if (bus.iAbort) begin
            state_reg <= IDLE;
          end else if (last_reg) begin
            state_reg <= DONE;
            busy_reg  <= 1'b1;
            done_reg  <= 1'b1;
          end else begin
            busy_reg  <= 1'b1;
            en_reg    <= 1'b1;
            cycle_reg <= cycle_next;
            last_reg  <= &cycle_next;
          end
        end

        DONE: begin
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.oBusy  = busy_reg;
  assign bus.oDone  = done_reg;
  assign bus.oLoadW = loadw_reg;
  assign bus.oWReal = wreal_reg;
  assign bus.oWImg  = wimg_reg;
  assign bus.oClr   = clr_reg;
  assign bus.oEn    = en_reg;
  assign bus.oCycle = cycle_reg;
  assign bus.oLast  = last_reg;

endmodule

// File: doc/sfft_sequencer.md
# sfft_sequencer

Control sequencer for the unary scaler SFFT datapath. It holds a host-programmed twiddle table, streams it into the butterfly array under `oLoadW`, issues a one-cycle clear, and then holds enable for exactly one full bitstream window of 2^BITWIDTH cycles. It finishes with a done pulse. It sits between the host/config interface and the SFFT's `iEn`/`loadW`/`iClr`/`iwReal`/`iwImg` inputs.

## Interface
Parameters:
- BITWIDTH, 8, twiddle word width; the run window is 2^BITWIDTH cycles.
- NUMTW, 4, number of twiddle entries (≥2).
- TWAW, $clog2(NUMTW), table address width.

Ports:
- iClk  in  1  clock; all state changes on the rising edge.
- iRst  in  1  reset, asynchronous, active-high.
- iStart  in  1  start request; sampled only in IDLE.
- iAbort  in  1  abort the current sequence; sampled in every non-IDLE state.
- iCfgWe  in  1  table write strobe; honoured only in IDLE.
- iCfgAddr  in  TWAW  table write address.
- iCfgReal  in  BITWIDTH  real twiddle value to write.
- iCfgImg  in  BITWIDTH  imaginary twiddle value to write.
- oBusy  out  1  high in every state except IDLE.
- oDone  out  1  one-cycle pulse at normal completion.
- oLoadW  out  1  drives SFFT loadW.
- oWReal  out  BITWIDTH  drives SFFT iwReal.
- oWImg  out  BITWIDTH  drives SFFT iwImg.
- oClr  out  1  drives SFFT iClr.
- oEn  out  1  drives SFFT iEn.
- oCycle  out  BITWIDTH  index of the current run cycle.
- oLast  out  1  high on the final run cycle.

## Operation
- All outputs are registered.
- Reset values: state IDLE; table entries all 0; every output 0, including oWReal, oWImg and oCycle.
- State machine: IDLE → LOAD → CLEAR → RUN → DONE → IDLE.
- IDLE
  - iCfgWe=1 writes {iCfgReal, iCfgImg} to table[iCfgAddr].
  - An address ≥ NUMTW is ignored.
  - iStart=1 moves to LOAD and clears the load index.
  - If iCfgWe and iStart are high in the same cycle, the write completes and the loaded value is the new one.
- LOAD: NUMTW cycles.
  - oLoadW=1.
  - oWReal/oWImg = table[k] on load cycle k, for k = 0..NUMTW-1, in ascending order.
  - After entry NUMTW-1, go to CLEAR.
- CLEAR: exactly 1 cycle with oClr=1, oLoadW=0 and oEn=0.
- RUN: 2^BITWIDTH cycles.
  - oEn=1.
  - oCycle counts 0 .. 2^BITWIDTH-1.
  - oLast=1 only when oCycle = 2^BITWIDTH-1.
  - The counter wraps to 0 on exit.
- DONE: 1 cycle with oDone=1 and oEn=0, then IDLE.
- Output values outside their active state:
  - oWReal/oWImg are 0 outside LOAD.
  - oCycle is 0 outside RUN.
- Writes and starts while busy:
  - iCfgWe outside IDLE is dropped; the table is unchanged.
  - iStart outside IDLE is ignored and is not queued. This includes DONE.
- Abort:
  - iAbort=1 in LOAD, CLEAR or RUN moves the next state to IDLE.
  - All outputs are 0 on the following cycle, and no oDone is produced.
  - In DONE, iAbort has no effect.
- Simultaneous events: iAbort has priority over the normal state advance, including on the oLast cycle.
- Reset asserted mid-operation forces the reset values immediately (asynchronously). The table is also cleared.

## Timing
- Take the edge that samples iStart=1 as edge 0. Then:
  - Cycles 1..NUMTW: LOAD.
  - Cycle NUMTW+1: CLEAR.
  - Cycles NUMTW+2 .. NUMTW+1+2^BITWIDTH: RUN.
  - Cycle NUMTW+2+2^BITWIDTH: DONE.
  - The following cycle: IDLE.
- With the defaults: LOAD is cycles 1–4, CLEAR is 5, RUN is 6–261, oDone is at 262, and iStart is accepted again at 263.
- oBusy rises at cycle 1 and falls with the DONE→IDLE transition.
- A table write is visible to a start sampled on the next cycle.

## Test plan
- Reset and idle outputs:
  - Stimulus: assert iRst mid-RUN (e.g. oCycle=100).
  - Required response: all outputs read 0 immediately; after release, a start loads table entries of 0.
- Nominal sequence with defaults:
  - Stimulus: write table = {(0x10,0x01),(0x20,0x02),(0x30,0x03),(0x40,0x04)}, then pulse iStart.
  - Required response: oLoadW at cycles 1–4 with those values in order; oClr at 5; oEn at 6–261 with oCycle 0–255 and oLast at 261; oDone at 262.
- Ignored inputs while busy:
  - Stimulus: iCfgWe to addr 0 with 0xFF during RUN; iStart during RUN and during DONE.
  - Required response: table[0] stays 0x10; no second sequence starts; the next iStart is accepted only from IDLE.
- Abort:
  - Stimulus: iAbort at the oLast cycle.
  - Required response: IDLE next cycle, oDone never asserts, oEn=0.
  - Stimulus: iAbort during LOAD entry 2.
  - Required response: oLoadW drops next cycle, and there is no oClr.
- Same-cycle write and start:
  - Stimulus: iCfgWe to addr 3 with (0xAA,0x55) together with iStart.
  - Required response: load cycle 4 presents 0xAA/0x55.
- Out-of-range and parameter sweep:
  - Stimulus: with NUMTW=3 and BITWIDTH=4, write to address 3.
  - Required response: the write is ignored; run length is 16 cycles; oDone at edge 3+1+16+1 = 21.
